// File: rtl/adder_4b_rtl_if.sv
// Operand/result bundle for the 4-bit adder: operands in, combinational and
// registered results plus overflow counter out.
interface adder_4b_rtl_if;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] sum;
  logic       cout;
  logic [3:0] sum_q;
  logic       cout_q;
  logic       valid_q;
  logic [3:0] ovf_cnt;

  modport master (
    output a, b,
    input  sum, cout, sum_q, cout_q, valid_q, ovf_cnt
  );

  modport slave (
    input  a, b,
    output sum, cout, sum_q, cout_q, valid_q, ovf_cnt
  );
endinterface

// File: rtl/adder_4b_rtl.sv
// 4-bit ripple-carry adder with a registered copy of the result, a valid flag
// and a saturating count of carry-out cycles.
module adder_4b_rtl (
  input  logic           clk,
  input  logic           reset,
  adder_4b_rtl_if.slave  bus
);

  logic [4:0] carry;
  logic [3:0] sum_c;
  logic [3:0] sum_r;
  logic       cout_r;
  logic       valid_r;
  logic [3:0] ovf_r;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum_c[i]   = bus.a[i] ^ bus.b[i] ^ carry[i];
    assign carry[i+1] = (bus.a[i] & bus.b[i]) |
                        (bus.a[i] & carry[i]) |
                        (bus.b[i] & carry[i]);
  end

  assign bus.sum  = sum_c;
  assign bus.cout = carry[4];

  // Reset wins over load and count, even on a carry-out edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r   <= 4'd0;
      cout_r  <= 1'b0;
      valid_r <= 1'b0;
      ovf_r   <= 4'd0;
    end else begin
      sum_r   <= sum_c;
      cout_r  <= carry[4];
      valid_r <= 1'b1;
      if (carry[4] && (ovf_r != 4'hF)) begin
        ovf_r <= ovf_r + 4'd1;
      end
    end
  end

  assign bus.sum_q   = sum_r;
  assign bus.cout_q  = cout_r;
  assign bus.valid_q = valid_r;
  assign bus.ovf_cnt = ovf_r;

endmodule

// File: tb/tb_adder_4b_rtl.sv
// Directed bench for adder_4b_rtl: combinational sums, registered path,
// counter saturation, reset priority and an exhaustive operand sweep.
module tb_adder_4b_rtl;

  logic clk;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  adder_4b_rtl_if bus ();

  adder_4b_rtl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic rv);
    @(negedge clk);
    bus.a = av;
    bus.b = bv;
    reset = rv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [3:0] s, input logic c,
                            input logic v, input logic [3:0] n);
    check_val({tag, "_sum_q"}, {4'd0, bus.sum_q}, {4'd0, s});
    check_val({tag, "_cout_q"}, {7'd0, bus.cout_q}, {7'd0, c});
    check_val({tag, "_valid_q"}, {7'd0, bus.valid_q}, {7'd0, v});
    check_val({tag, "_ovf_cnt"}, {4'd0, bus.ovf_cnt}, {4'd0, n});
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       c;
  } comb_vec_t;

  comb_vec_t comb_tbl[7] = '{
    '{4'd0, 4'd0, 4'd0,  1'b0},
    '{4'd1, 4'd1, 4'd2,  1'b0},
    '{4'd2, 4'd3, 4'd5,  1'b0},
    '{4'd5, 4'd7, 4'd12, 1'b0},
    '{4'd7, 4'd8, 4'd15, 1'b0},
    '{4'd8, 4'd8, 4'd0,  1'b1},
    '{4'd8, 4'd9, 4'd1,  1'b1}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_cnt;
    int total;
    vec_cnt = 0;
    err_cnt = 0;
    reset   = 1'b1;
    bus.a   = 4'd0;
    bus.b   = 4'd0;

    tick();
    tick();
    check_regs("reset", 4'd0, 1'b0, 1'b0, 4'd0);

    // Combinational table applied while reset is held: results must still track.
    foreach (comb_tbl[i]) begin
      drive(comb_tbl[i].a, comb_tbl[i].b, 1'b1);
      #1;
      check_val($sformatf("comb_sum_%0d_%0d", comb_tbl[i].a, comb_tbl[i].b),
                {4'd0, bus.sum}, {4'd0, comb_tbl[i].s});
      check_val($sformatf("comb_cout_%0d_%0d", comb_tbl[i].a, comb_tbl[i].b),
                {7'd0, bus.cout}, {7'd0, comb_tbl[i].c});
    end
    tick();
    check_regs("reset_hold", 4'd0, 1'b0, 1'b0, 4'd0);

    drive(4'd5, 4'd7, 1'b0);
    tick();
    check_regs("reg_5_7", 4'd12, 1'b0, 1'b1, 4'd0);

    drive(4'd0, 4'd0, 1'b1);
    tick();
    check_regs("reset_mid", 4'd0, 1'b0, 1'b0, 4'd0);

    drive(4'd8, 4'd9, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_val($sformatf("sat_ovf_%0d", i), {4'd0, bus.ovf_cnt}, (i > 15) ? 8'd15 : 8'(i));
    end
    check_regs("sat_end", 4'd1, 1'b1, 1'b1, 4'd15);

    drive(4'd1, 4'd1, 1'b0);
    tick();
    check_regs("hold_no_carry", 4'd2, 1'b0, 1'b1, 4'd15);

    drive(4'd0, 4'd0, 1'b1);
    tick();
    drive(4'd8, 4'd9, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check_val("prio_pre_ovf", {4'd0, bus.ovf_cnt}, 8'd5);

    drive(4'd15, 4'd15, 1'b1);
    #1;
    check_val("prio_comb_sum", {4'd0, bus.sum}, 8'd14);
    check_val("prio_comb_cout", {7'd0, bus.cout}, 8'd1);
    tick();
    check_regs("prio", 4'd0, 1'b0, 1'b0, 4'd0);
    check_val("prio_comb_sum_after", {4'd0, bus.sum}, 8'd14);

    drive(4'd15, 4'd15, 1'b0);
    tick();
    check_regs("resume", 4'd14, 1'b1, 1'b1, 4'd1);

    drive(4'd0, 4'd0, 1'b1);
    tick();
    exp_cnt = 0;
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        drive(4'(av), 4'(bv), 1'b0);
        total = av + bv;
        #1;
        check_val($sformatf("exh_comb_%0d_%0d", av, bv), {3'd0, bus.cout, bus.sum}, 8'(total));
        if (total >= 16 && exp_cnt < 15) exp_cnt++;
        tick();
        check_val($sformatf("exh_reg_%0d_%0d", av, bv), {3'd0, bus.cout_q, bus.sum_q}, 8'(total));
        check_val($sformatf("exh_ovf_%0d_%0d", av, bv), {4'd0, bus.ovf_cnt}, 8'(exp_cnt));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/adder_4b_rtl.md
ADDER_4B_RTL -- requirements
Module: adder_4b_rtl

Interface
REQ-001 Parameters: none; all widths fixed at 4 bits.
REQ-002 Single clock and reset: the block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all registered outputs.
REQ-004 reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 a  input  4  unsigned operand A.
REQ-006 b  input  4  unsigned operand B.
REQ-007 sum  output  4  combinational (a + b) mod 16.
REQ-008 cout  output  1  combinational carry-out of a + b.
REQ-009 sum_q  output  4  sum registered on rising clk.
REQ-010 cout_q  output  1  cout registered on rising clk.
REQ-011 valid_q  output  1  high once sum_q/cout_q hold a post-reset sample.
REQ-012 ovf_cnt  output  4  saturating count of clock edges where cout was 1.

Function
REQ-013 sum SHALL equal the low 4 bits of a + b, with no clock edge required.
REQ-014 cout SHALL equal bit 4 of the 5-bit sum a + b.
REQ-015 sum and cout SHALL settle within one time unit of an input change, independent of clk and reset.
REQ-016 Wrap-around: any a + b >= 16 SHALL produce sum = a + b - 16 and cout = 1 (e.g. 8+8 -> sum 0, cout 1; 15+15 -> sum 14, cout 1).
REQ-017 Sums of 15 or less SHALL produce cout = 0.
REQ-018 On each rising clk with reset = 0, sum_q and cout_q SHALL load the current sum and cout (latency 1 cycle).
REQ-019 On each rising clk with reset = 0, valid_q SHALL be set to 1.
REQ-020 On each rising clk with reset = 0 and cout = 1, ovf_cnt SHALL increment by 1.
REQ-021 ovf_cnt SHALL saturate at 15 and never wrap to 0.
REQ-022 On a rising clk with reset = 0 and cout = 0, ovf_cnt SHALL hold its value.
REQ-023 The combinational path SHALL use a ripple-carry chain of four full adders, each with sum = x^y^c and carry = majority(x,y,c), with carry-in to bit 0 fixed at 0.
REQ-024 Outputs SHALL never be X/Z when a and b are known.

Reset
REQ-025 Reset is synchronous: it SHALL take effect only on a rising clk.
REQ-026 On a rising clk with reset = 1, the block SHALL clear sum_q, cout_q, valid_q and ovf_cnt to 0.
REQ-027 Reset SHALL take priority over loading and counting on the same edge, including when cout = 1.
REQ-028 sum and cout SHALL be unaffected by reset and track a and b throughout reset.
REQ-029 Reset asserted mid-operation SHALL clear the registers on the next edge.
REQ-030 After reset deasserts, normal operation SHALL resume on the following edge.

Verification
REQ-031 Simple sums SHALL produce the following sum values within 1 time unit: a=0,b=0 -> 0; 1,1 -> 2; 2,3 -> 5; 5,7 -> 12; 7,8 -> 15; cout = 0 in every case.
REQ-032 Overflow SHALL produce: a=8,b=8 -> sum 0, cout 1; a=8,b=9 -> sum 1, cout 1.
REQ-033 Registered path: with reset held 1 then released and a=5,b=7 applied, one clk edge SHALL give sum_q=12, cout_q=0, valid_q=1.
REQ-034 Counter saturation: with a=8,b=9 held for 20 edges after reset, ovf_cnt SHALL read 1,2,…,15 and then stay at 15.
REQ-035 Reset priority: with ovf_cnt=5 and a=15,b=15, a clk edge with reset=1 SHALL give ovf_cnt=0, valid_q=0, sum_q=0, while combinational sum=14 and cout=1.
REQ-036 Exhaustive check: all 256 (a,b) pairs SHALL give combinational {cout,sum} = a+b, and sum_q/cout_q SHALL match one edge later.
